// File: rtl/fifo_pkt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkt_sequencer_pkg
// Description : Shared types and constants for the packet FIFO sequencer:
//               FSM state encoding, SRAM word geometry and field offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkt_sequencer_pkg;

    localparam int c_ADDR_WIDTH = 8;
    localparam int c_DATA_WIDTH = 64;
    localparam int c_CTRL_WIDTH = 8;
    localparam int c_WORD_WIDTH = c_CTRL_WIDTH + c_DATA_WIDTH;

    // Stored word is {ctrl, data}: data occupies the low bits.
    localparam int c_DATA_LSB = 0;
    localparam int c_CTRL_LSB = c_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_HOLD = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : fifo_port_mux
// Description : Single SRAM port shared between the CPU register path and
//               the packet sequencer. The CPU has priority, but a CPU win in
//               RD is remembered so the next RD cycle goes to the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_port_mux #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 72
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seq_rd,       // FSM sits in RD
    input  logic                  seq_wr,       // FSM sits in WR
    input  logic                  cpu_ok,       // FSM state lets the CPU in freely
    input  logic [ADDR_WIDTH-1:0] seq_addr,
    input  logic [WORD_WIDTH-1:0] seq_wdata,
    input  logic                  cpu_req,
    input  logic                  cpu_wen,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  seq_rd_win,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_wen,
    output logic [WORD_WIDTH-1:0] sram_wdata
);

    logic r_lost;
    logic w_cpu_wins_rd;

    // CPU may steal an RD cycle only if the previous RD cycle was not stolen.
    always_comb begin
        w_cpu_wins_rd = seq_rd & cpu_req & ~r_lost;
    end

    // Port ownership; everything is held at its idle value while in reset.
    always_comb begin
        cpu_gnt    = 1'b0;
        seq_rd_win = 1'b0;
        sram_addr  = '0;
        sram_wen   = 1'b0;
        sram_wdata = '0;
        if (!reset) begin
            cpu_gnt    = cpu_req & (cpu_ok | w_cpu_wins_rd);
            seq_rd_win = seq_rd & ~w_cpu_wins_rd;
            if (cpu_gnt) begin
                sram_addr  = cpu_addr;
                sram_wen   = cpu_wen;
                sram_wdata = cpu_wdata;
            end else if (seq_rd_win || seq_wr) begin
                sram_addr  = seq_addr;
                sram_wen   = seq_wr;
                sram_wdata = seq_wdata;
            end
        end
    end

    // Alternation flag: updated on every RD cycle with who won it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lost <= 1'b0;
        end else if (seq_rd) begin
            r_lost <= w_cpu_wins_rd;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_pkt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkt_sequencer
// Description : Walks a stored packet from head to tail, XORs the data part
//               of every data word (ctrl == 0) with a mask, writes it back in
//               place and pulses done. Shares the SRAM port with the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pkt_sequencer
    import fifo_pkt_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int CTRL_WIDTH = c_CTRL_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             pkt_rdy,
    input  logic [ADDR_WIDTH-1:0]            head_addr,
    input  logic [ADDR_WIDTH-1:0]            tail_addr,
    input  logic [DATA_WIDTH-1:0]            xor_mask,
    input  logic                             cpu_req,
    input  logic                             cpu_wen,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_wdata,
    output logic                             cpu_gnt,
    output logic                             cpu_rvalid,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic                             sram_wen,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0] sram_wdata,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] sram_rdata,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH:0]              word_cnt
);

    localparam int c_WORD_W = CTRL_WIDTH + DATA_WIDTH;

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [c_WORD_W-1:0]   r_buf;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic                  r_cpu_rvalid;
    logic [c_WORD_W-1:0]   w_wr_word;
    logic                  w_seq_rd_win;
    logic                  w_cpu_ok;
    logic                  w_start;

    always_comb begin
        w_start  = en & pkt_rdy;
        w_cpu_ok = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_HOLD);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RD waits for a won cycle, WR loops until the tail.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_RD;
            S_RD:    if (w_seq_rd_win) w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_WR;
            S_WR:    w_state_next = (r_addr == r_tail) ? S_DONE : S_RD;
            S_DONE:  w_state_next = S_HOLD;
            S_HOLD:  if (!pkt_rdy) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Packet datapath: latch bounds, capture read word, advance on write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_tail     <= '0;
            r_buf      <= '0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr     <= head_addr;
                        r_tail     <= tail_addr;
                        r_word_cnt <= '0;
                    end
                end
                S_WAIT: r_buf <= sram_rdata;
                S_WR: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (r_addr != r_tail) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back word: only data words (ctrl == 0) get the mask.
    always_comb begin
        w_wr_word = r_buf;
        if (r_buf[c_CTRL_LSB +: CTRL_WIDTH] == '0) begin
            w_wr_word[c_DATA_LSB +: DATA_WIDTH] = r_buf[c_DATA_LSB +: DATA_WIDTH] ^ xor_mask;
        end
    end

    // CPU read data arrives one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= cpu_gnt & ~cpu_wen;
        end
    end

    fifo_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (c_WORD_W)
    ) u_port_mux (
        .clk        (clk),
        .reset      (reset),
        .seq_rd     (r_state == S_RD),
        .seq_wr     (r_state == S_WR),
        .cpu_ok     (w_cpu_ok),
        .seq_addr   (r_addr),
        .seq_wdata  (w_wr_word),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .seq_rd_win (w_seq_rd_win),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_wdata (sram_wdata)
    );

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = sram_rdata;
    assign busy       = (r_state == S_RD) | (r_state == S_WAIT) |
                        (r_state == S_WR) | (r_state == S_DONE);
    assign done       = (r_state == S_DONE);
    assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_pkt_sequencer
// Description : Scoreboard bench for fifo_pkt_sequencer with an SRAM model,
//               a CPU read traffic generator and a packet-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_sequencer;

    logic        clk = 1'b0;
    logic        reset, en, pkt_rdy;
    logic [7:0]  head_addr, tail_addr;
    logic [63:0] xor_mask;
    wire         cpu_req, cpu_wen;
    wire  [7:0]  cpu_addr;
    wire  [71:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, sram_wen, busy, done;
    logic [71:0] cpu_rdata, sram_wdata;
    logic [71:0] sram_rdata = '0;
    logic [7:0]  sram_addr;
    logic [8:0]  word_cnt;

    // CPU port is driven either by the background generator (d_*) or the
    // main stimulus (s_*); the two are never active together.
    logic        d_req, s_req, s_wen;
    logic [7:0]  d_addr, s_addr;
    logic [71:0] s_wdata;
    assign cpu_req   = d_req | s_req;
    assign cpu_wen   = s_req ? s_wen : 1'b0;
    assign cpu_addr  = s_req ? s_addr : d_addr;
    assign cpu_wdata = s_wdata;

    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [71:0] bd_data;
    logic [71:0] mem     [256] = '{default: '0};
    logic [71:0] ref_mem [256] = '{default: '0};

    logic [71:0] rd_q[$];
    int          done_q[$];
    int          cpu_mode;
    logic [7:0]  cpu_base;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fifo_pkt_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pkt_rdy    (pkt_rdy),
        .head_addr  (head_addr),
        .tail_addr  (tail_addr),
        .xor_mask   (xor_mask),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    // SRAM model: synchronous write, registered read; bench backdoor port.
    always @(posedge clk) begin
        if (sram_wen) mem[sram_addr] <= sram_wdata;
        if (bd_we) mem[bd_addr] <= bd_data;
        sram_rdata <= mem[sram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [71:0] w);
        bd_we = 1'b1; bd_addr = a; bd_data = w;
        tick();
        bd_we = 1'b0;
        ref_mem[a] = w;
    endtask

    // Random packet contents: mostly data words, some header words.
    task automatic fill(input logic [7:0] h, input int n);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            bd_write(h + 8'(i), {c, $urandom, $urandom});
        end
    endtask

    // Reference effect of one full pass over a packet.
    task automatic model_pass(input logic [7:0] h, input int n, input logic [63:0] m);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = h + 8'(i);
            if (ref_mem[a][71:64] == 8'h00) ref_mem[a][63:0] = ref_mem[a][63:0] ^ m;
        end
    endtask

    task automatic mem_compare(input logic [7:0] h, input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = h + 8'(i);
            check($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
        end
    endtask

    // mode: 0 no CPU traffic, 1 CPU reads held continuously, 2 random reads.
    task automatic run_pkt(input logic [7:0] h, input int n, input logic [63:0] m,
                           input int mode, input int hold);
        int k, lo, hi;
        bit seen;
        model_pass(h, n, m);
        done_q.push_back(n);
        head_addr = h; tail_addr = h + 8'(n - 1); xor_mask = m;
        cpu_base = h + 8'(n + 8); cpu_mode = mode;
        if (mode != 0) repeat (2) tick();
        pkt_rdy = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 3000) begin
            tick(); k++;
            if (k == 1) check("busy_rd_entry", busy, 1'b1);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", done, 1'b1);
        end else begin
            lo = 3 * n + 1;
            hi = (mode == 0) ? lo : 4 * n + 1;
            if (mode == 1) lo = hi;
            checks++;
            if (k < lo || k > hi) begin
                errors++;
                $display("FAIL done_cycle: got %0d expected %0d..%0d", k, lo, hi);
            end
            check("busy_done", busy, 1'b1);
        end
        cpu_mode = 0;
        repeat (hold) tick();
        pkt_rdy = 1'b0;
        repeat (3) tick();
        check("busy_idle", busy, 1'b0);
        k = 0;
        while (d_req && k < 200) begin tick(); k++; end
        repeat (2) tick();
        mem_compare(h, n);
    endtask

    // Background CPU reader: holds each request until granted.
    initial begin : cpu_driver
        bit g;
        d_req = 1'b0; d_addr = '0;
        forever begin
            @(negedge clk);
            g = d_req && cpu_gnt;
            if (g) rd_q.push_back(ref_mem[d_addr]);
            @(posedge clk); #1;
            if (g || !d_req) begin
                if (cpu_mode == 1 || (cpu_mode == 2 && $urandom_range(0, 1) == 1)) begin
                    d_req  = 1'b1;
                    d_addr = cpu_base + 8'($urandom_range(0, 40));
                end else begin
                    d_req = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected responses whenever the DUT presents one.
    initial begin : monitor
        logic [71:0] e;
        int          n;
        forever begin
            @(negedge clk);
            if (cpu_rvalid) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", cpu_rvalid, 1'b0);
                else begin e = rd_q.pop_front(); check("cpu_rdata", cpu_rdata, e); end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 1'b0);
                else begin n = done_q.pop_front(); check("word_cnt", word_cnt, 72'(n)); end
            end
        end
    end

    initial begin : stim
        logic [7:0]  h;
        logic [63:0] m;
        int          k, n;
        reset = 1'b1; en = 1'b1; pkt_rdy = 1'b0;
        head_addr = '0; tail_addr = '0; xor_mask = '0;
        s_req = 1'b0; s_wen = 1'b0; s_addr = '0; s_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        cpu_mode = 0; cpu_base = '0;
        repeat (3) tick();
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", cpu_gnt, 1'b0);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_wen", sram_wen, 1'b0);
        check("rst_addr", sram_addr, 8'd0);
        check("rst_word_cnt", word_cnt, 9'd0);
        reset = 1'b0;
        tick();

        // Basic packet with fixed words.
        bd_write(8'd10, {8'hFF, 64'h0123_4567_89AB_CDEF});
        bd_write(8'd11, {8'h00, 64'h1111_2222_3333_4444});
        bd_write(8'd12, {8'h00, 64'h5555_6666_7777_8888});
        run_pkt(8'd10, 3, 64'hFF, 0, 0);
        check("basic_w10", mem[10], {8'hFF, 64'h0123_4567_89AB_CDEF});
        check("basic_w11", mem[11], {8'h00, 64'h1111_2222_3333_44BB});
        check("basic_w12", mem[12], {8'h00, 64'h5555_6666_7777_8877});

        // Address wrap 254..1.
        fill(8'd254, 4);
        run_pkt(8'd254, 4, {$urandom, $urandom}, 0, 0);

        // Continuous CPU reads during a 4-word packet.
        fill(8'd20, 4);
        run_pkt(8'd20, 4, {$urandom, $urandom}, 1, 0);

        // pkt_rdy held after done, then a second pass over the same packet.
        fill(8'd40, 5);
        m = {$urandom, $urandom};
        run_pkt(8'd40, 5, m, 0, 20);
        run_pkt(8'd40, 5, m, 0, 0);

        // Reset during the WR of word 2; first word already written back.
        fill(8'd30, 4);
        m = {$urandom, $urandom};
        model_pass(8'd30, 1, m);
        model_pass(8'd30, 4, m);
        done_q.push_back(4);
        head_addr = 8'd30; tail_addr = 8'd33; xor_mask = m;
        pkt_rdy = 1'b1;
        repeat (6) tick();
        reset = 1'b1; s_req = 1'b1; s_wen = 1'b0; s_addr = 8'd200;
        tick();
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_gnt", cpu_gnt, 1'b0);
        check("mid_rst_rvalid", cpu_rvalid, 1'b0);
        check("mid_rst_wen", sram_wen, 1'b0);
        check("mid_rst_addr", sram_addr, 8'd0);
        check("mid_rst_word_cnt", word_cnt, 9'd0);
        reset = 1'b0; s_req = 1'b0;
        tick();
        check("rerun_addr", sram_addr, 8'd30);
        check("rerun_wen", sram_wen, 1'b0);
        check("rerun_busy", busy, 1'b1);
        k = 8;
        while (!done && k < 200) begin tick(); k++; end
        check("rerun_done_cycle", 72'(k), 72'd20);
        pkt_rdy = 1'b0;
        repeat (3) tick();
        mem_compare(8'd30, 4);

        // Disabled: pkt_rdy ignored, CPU passes straight through.
        en = 1'b0; pkt_rdy = 1'b1;
        repeat (40) begin
            s_req   = 1'($urandom_range(0, 1));
            s_wen   = 1'($urandom_range(0, 1));
            s_addr  = 8'($urandom_range(0, 15));
            s_wdata = {8'($urandom), $urandom, $urandom};
            #1;
            check("dis_gnt", cpu_gnt, s_req);
            check("dis_busy", busy, 1'b0);
            if (s_req) begin
                if (s_wen) ref_mem[s_addr] = s_wdata;
                else rd_q.push_back(ref_mem[s_addr]);
            end
            tick();
        end
        s_req = 1'b0; pkt_rdy = 1'b0;
        tick();
        en = 1'b1;
        repeat (2) tick();

        // Full wrap: tail == head - 1.
        h = 8'($urandom);
        fill(h, 256);
        run_pkt(h, 256, {$urandom, $urandom}, 0, 0);

        // Randomized packets with mixed CPU traffic.
        repeat (8) begin
            h = 8'($urandom);
            n = $urandom_range(1, 16);
            fill(h, n);
            run_pkt(h, n, {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        repeat (4) tick();
        check("rd_q_empty", 72'(rd_q.size()), 72'd0);
        check("done_q_empty", 72'(done_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
